// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_pkg
// Brief   : J/K drive encodings and target-bit helper for the JK counter.
// Revision: 1.0 - initial release
// ============================================================================
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Returns {J,K} that forces a cell to the given bit value on the next edge.
    function automatic logic [1:0] jk_for_target(input logic target);
        return target ? JK_SET : JK_RST;
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module  : jk_cell
// Brief   : Single JK flip-flop with asynchronous active-low reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : jk_mod_counter
// Brief   : Modulo-N up/down counter built from JK cells, with clear, load,
//           terminal-count, wrap and out-of-range-load indications.
// Revision: 1.0 - initial release
// ============================================================================
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_next;
    logic             w_err_next;
    logic             w_carry;
    logic [WIDTH-1:0] w_load_v;
    logic             r_wrap;
    logic             r_load_err;

    assign w_at_max  = (q == c_max);
    assign w_at_zero = (q == c_zero);
    assign w_load_v  = (load_val > c_max) ? c_max : load_val;

    always_comb begin
        j_vec       = '0;
        k_vec       = '0;
        w_wrap_next = 1'b0;
        w_err_next  = 1'b0;
        w_carry     = 1'b1;
        if (clr) begin
            k_vec = '1;
        end else if (load) begin
            w_err_next = (load_val > c_max);
            for (int i = 0; i < WIDTH; i++) begin
                {j_vec[i], k_vec[i]} = jk_for_target(w_load_v[i]);
            end
        end else if (en) begin
            if (up_dn && w_at_max) begin
                k_vec       = '1;
                w_wrap_next = 1'b1;
            end else if (!up_dn && w_at_zero) begin
                w_wrap_next = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    {j_vec[i], k_vec[i]} = jk_for_target(c_max[i]);
                end
            end else begin
                // Ripple the toggle condition: all-ones below for up, all-zeros for down.
                for (int i = 0; i < WIDTH; i++) begin
                    j_vec[i] = w_carry;
                    k_vec[i] = w_carry;
                    w_carry  = w_carry & (up_dn ? q[i] : ~q[i]);
                end
            end
        end
    end

    assign tc = en & ~clr & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= w_wrap_next;
            r_load_err <= w_err_next;
        end
    end

    assign wrap     = r_wrap;
    assign load_err = r_load_err;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (j_vec[g]),
                .k     (k_vec[g]),
                .q     (q[g])
            );
        end
    endgenerate

endmodule : jk_mod_counter
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_mod_counter
// Brief   : Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
// Revision: 1.0 - initial release
// ============================================================================
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, load, clr;
    logic [3:0] load_val;
    logic [3:0] q, j_vec, k_vec;
    logic       tc, wrap, load_err;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       wrap;
        logic       lerr;
        logic       chk_jk;
        logic [3:0] j;
        logic [3:0] k;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   obs    = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err),
        .j_vec    (j_vec),
        .k_vec    (k_vec)
    );

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                obs++;
                checks++;
                if (q !== e.q || tc !== e.tc || wrap !== e.wrap || load_err !== e.lerr ||
                    (e.chk_jk && (j_vec !== e.j || k_vec !== e.k))) begin
                    errors++;
                    $display("FAIL cycle%0d: got q=%0d tc=%b wrap=%b lerr=%b j=%b k=%b, want q=%0d tc=%b wrap=%b lerr=%b j=%b k=%b (jk checked=%b)",
                             obs, q, tc, wrap, load_err, j_vec, k_vec,
                             e.q, e.tc, e.wrap, e.lerr, e.j, e.k, e.chk_jk);
                end
            end
        end
    end

    task automatic cyc(input logic i_en, input logic i_up, input logic i_ld,
                       input logic [3:0] i_lv, input logic i_clr,
                       input logic [3:0] eq, input logic etc, input logic ew,
                       input logic ele, input logic chk,
                       input logic [3:0] ej, input logic [3:0] ek);
        exp_t e;
        @(posedge clk);
        #1;
        en = i_en; up_dn = i_up; load = i_ld; load_val = i_lv; clr = i_clr;
        e.q = eq; e.tc = etc; e.wrap = ew; e.lerr = ele;
        e.chk_jk = chk; e.j = ej; e.k = ek;
        sb.push_back(e);
    endtask

    task automatic cycn(input logic i_en, input logic i_up, input logic i_ld,
                        input logic [3:0] i_lv, input logic i_clr,
                        input logic [3:0] eq, input logic etc, input logic ew,
                        input logic ele);
        cyc(i_en, i_up, i_ld, i_lv, i_clr, eq, etc, ew, ele, 1'b0, 4'b0, 4'b0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; en = 0; up_dn = 0; load = 0; clr = 0; load_val = 4'd0;

        // Reset held for two edges
        cycn(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        cycn(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;

        // Up count 0..9,0,1
        cycn(1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
        cyc (1, 1, 0, 0, 0, 4'd3, 0, 0, 0, 1, 4'b0111, 4'b0111);
        cycn(1, 1, 0, 0, 0, 4'd4, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd5, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd6, 0, 0, 0);
        cyc (1, 1, 0, 0, 0, 4'd7, 0, 0, 0, 1, 4'b1111, 4'b1111);
        cycn(1, 1, 0, 0, 0, 4'd8, 0, 0, 0);
        cyc (1, 1, 0, 0, 0, 4'd9, 1, 0, 0, 1, 4'b0000, 4'b1111);
        cycn(1, 1, 0, 0, 0, 4'd0, 0, 1, 0);
        cycn(1, 1, 0, 0, 0, 4'd1, 0, 0, 0);

        // Load 2, then count down 2,1,0,9,8
        cyc (0, 0, 1, 4'd2, 0, 4'd2, 0, 0, 0, 1, 4'b0010, 4'b1101);
        cyc (1, 0, 0, 0, 0, 4'd2, 0, 0, 0, 1, 4'b0011, 4'b0011);
        cycn(1, 0, 0, 0, 0, 4'd1, 0, 0, 0);
        cyc (1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1, 4'b1001, 4'b0110);
        cycn(1, 0, 0, 0, 0, 4'd9, 0, 1, 0);
        cycn(1, 0, 0, 0, 0, 4'd8, 0, 0, 0);

        // Loads: in range, out of range, out of range with en
        cyc (0, 0, 1, 4'd7, 0, 4'd7, 0, 0, 0, 1, 4'b0111, 4'b1000);
        cyc (0, 0, 1, 4'd12, 0, 4'd7, 0, 0, 0, 1, 4'b1001, 4'b0110);
        cyc (1, 1, 1, 4'd15, 0, 4'd9, 0, 0, 1, 1, 4'b1001, 4'b0110);
        // Priority: clr+load+en at q=9 counting up
        cyc (1, 1, 1, 4'd5, 1, 4'd9, 0, 0, 1, 1, 4'b0000, 4'b1111);
        cycn(1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd3, 0, 0, 0);

        // Hold at 4 with up_dn wiggling
        cyc (0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc (0, 1, 0, 0, 0, 4'd4, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc (0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc (0, 1, 0, 0, 0, 4'd4, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc (0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 1, 4'b0000, 4'b0000);

        // Count to 6, then reset asynchronously between edges
        cycn(1, 1, 0, 0, 0, 4'd4, 0, 0, 0);
        cycn(1, 1, 0, 0, 0, 4'd5, 0, 0, 0);
        cyc (1, 1, 0, 0, 0, 4'd6, 0, 0, 0, 1, 4'b0001, 4'b0001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got q=%0d wrap=%b lerr=%b, want q=0 wrap=0 lerr=0",
                     q, wrap, load_err);
        end
        cycn(0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        rst_n = 1'b1;
        cycn(1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
        cycn(0, 1, 0, 0, 0, 4'd1, 0, 0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_jk_mod_counter
`default_nettype wire

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter.
- Each state bit is held in a JK flip-flop cell. Per-bit J/K drive is computed combinationally from the count mode.
- This is the downstream consumer of the SR-to-JK converted flop: it instantiates JK-behaviour cells and sequences their J/K inputs to build a usable counter.
- It sits between control logic (enable/load/direction) and anything needing a count, terminal-count or wrap indication.

Parameters:
- WIDTH, 4, number of state bits / JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- clr  input  1  synchronous clear.
- q  output  WIDTH  current count (JK cell outputs).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.
- j_vec  output  WIDTH  per-bit J drive, combinational, for debug/verification.
- k_vec  output  WIDTH  per-bit K drive, combinational, for debug/verification.

Behaviour:
- Reset:
  - rst_n low immediately forces q=0, wrap=0, load_err=0, independent of clk.
  - Release is synchronous to the next rising edge; the first update happens at the first edge with rst_n high.
- Priority each edge: clr > load > en count > hold.
- JK cell: J/K = 00 hold, 01 reset, 10 set, 11 toggle. q updates on the rising edge; latency is 1 cycle from inputs to q.
- clr: every bit driven J/K=01; next q=0.
- load: bit i driven J=v[i], K=~v[i], where v = load_val if load_val < MODULUS, else MODULUS-1.
  - Out-of-range load sets load_err=1 for exactly the following cycle.
- Count up (en=1, up_dn=1):
  - If q==MODULUS-1: all bits J/K=01 (next q=0), wrap=1 next cycle.
  - Else bit i toggles (J=K=1) when q[i-1:0] are all 1; bit 0 always toggles. Other bits J=K=0.
- Count down (en=1, up_dn=0):
  - If q==0: bit i J=c[i], K=~c[i] with c=MODULUS-1 (next q=MODULUS-1), wrap=1 next cycle.
  - Else bit i toggles when q[i-1:0] are all 0; bit 0 always toggles.
- Hold (en=0, no clr/load): j_vec=k_vec=0; q unchanged; wrap and load_err return to 0.
- tc = en & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)). tc is masked by clr and load.
- wrap and load_err are single-cycle pulses and never stretch. Back-to-back wraps (MODULUS=2, en held) produce wrap high on consecutive cycles.
- Simultaneous clr+load+en: clr wins; no wrap, no load_err.
- Simultaneous load+en: load wins; no count that cycle.
- up_dn may change any cycle; the new direction applies at the next edge.
- Reset asserted mid-count: q=0 at once; pending pulses are cleared.
- Arithmetic: all comparisons are unsigned at WIDTH bits. MODULUS=2**WIDTH degenerates to natural binary wrap with identical pulse behaviour.

Decomposition:
- Shared package/include `jk_pkg`:
  - localparams JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
  - Function mapping a target bit to its J/K pair.
- One sub-module `jk_cell`:
  - Ports clk, rst_n, j, k, q.
  - Async active-low reset to 0.
  - Instantiated WIDTH times via generate.
- The top level holds only the J/K next-state logic and the wrap/load_err registers.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: hold rst_n=0 for 2 cycles, then pull rst_n low mid-count at q=6 between edges → q=0, wrap=0, load_err=0 within the same cycle, no clk edge needed.
- Up count: en=1, up_dn=1 from 0 for 12 cycles → q=0,1,…,9,0,1. tc=1 only while q=9. wrap=1 only in the cycle after 9→0. Ten-edge period.
- Down count: load 2, then en=1, up_dn=0 → q=2,1,0,9,8. tc=1 while q=0. wrap pulses once after 0→9. j_vec/k_vec=1001/0110 at q=0.
- Loads: load_val=7 → q=7, load_err=0. load_val=12 → q=9, load_err=1 for one cycle. load_val=15 with en=1 → q=9, no count.
- Priority: clr=1, load=1, load_val=5, en=1 at q=9 up → q=0, wrap=0, load_err=0, tc=0.
- Hold: en=0 at q=4 for 5 cycles → q stays 4, j_vec=k_vec=0000, tc=0. A toggled up_dn has no effect.
